// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline constants and the IF/ID bundle type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int              PC_W      = 32;
  localparam logic [PC_W-1:0] PC_STEP   = 32'd4;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;

  // IF/ID bundle, also consumed by the decode stage
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with flush (priority) and freeze.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   freeze,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= IF_ID_BUBBLE;
    end else if (flush) begin
      r_q <= IF_ID_BUBBLE;
    end else if (!freeze) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch: PC, next-PC select, IF/ID register.
//            Optional fetch/stall counters under IF_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        valid_out
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_next_pc;
  if_id_t          w_ifid_d;
  if_id_t          w_ifid_q;
  logic            w_unused_addr_lsbs;

  // Target low bits are forced to zero, so they never reach the PC
  assign w_unused_addr_lsbs = &{1'b0, branch_addr[1:0]};

  assign w_pc_plus4 = r_pc + PC_STEP;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (branch_taken) begin
      w_next_pc = {branch_addr[31:2], 2'b00};
    end else if (freeze) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign imem_addr = r_pc;

  assign w_ifid_d.pc    = w_pc_plus4;
  assign w_ifid_d.instr = imem_data;
  assign w_ifid_d.valid = 1'b1;

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .flush  (branch_taken),
    .freeze (freeze),
    .i_d    (w_ifid_d),
    .o_q    (w_ifid_q)
  );

  assign pc_out    = w_ifid_q.pc;
  assign instr_out = w_ifid_q.instr;
  assign valid_out = w_ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else if (!branch_taken) begin
      if (freeze) begin
        r_stall_count <= r_stall_count + 32'd1;
      end else begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [64];

  int checks   = 0;
  int failures = 0;

  // Reference state, advanced from the architectural rules each edge
  logic [31:0] m_pc, m_pcout, m_instr, m_fc, m_sc;
  logic        m_valid;

  if_stage #(.PC_RESET(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
`ifdef IF_PERF_CNT_EN
    .fetch_count  (fetch_count),
    .stall_count  (stall_count),
`endif
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  task automatic tick(input logic r, input logic f, input logic b, input logic [31:0] ba);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba;
    if (r) begin
      m_pc = RESET_PC; m_pcout = 0; m_instr = 0; m_valid = 0; m_fc = 0; m_sc = 0;
    end else if (b) begin
      m_pcout = 0; m_instr = 0; m_valid = 0;
      m_pc = ba & 32'hFFFF_FFFC;
    end else if (f) begin
      m_sc = m_sc + 1;
    end else begin
      m_instr = mem[m_pc[7:2]];
      m_pc    = m_pc + 4;
      m_pcout = m_pc;
      m_valid = 1'b1;
      m_fc    = m_fc + 1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0); tick(1, 1, 1, 32'h44); tick(1, 0, 0, 0);
    checks++;
    if ({imem_addr, pc_out, instr_out, valid_out} !== {RESET_PC, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset: addr=%h pc=%h instr=%h v=%b expected %h/0/0/0",
               imem_addr, pc_out, instr_out, valid_out, RESET_PC);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if ({fetch_count, stall_count} !== 64'h0) begin
      failures++;
      $display("FAIL reset_counters: fetch=%0d stall=%0d expected 0/0", fetch_count, stall_count);
    end
`endif
  endtask

  task automatic test_seq_fetch();
    tick(0, 0, 0, 0);
    checks++;
    if ({pc_out, instr_out, valid_out, imem_addr} !== {32'h4, mem[0], 1'b1, 32'h4}) begin
      failures++;
      $display("FAIL first_fetch: pc=%h instr=%h v=%b addr=%h expected 4/%h/1/4",
               pc_out, instr_out, valid_out, imem_addr, mem[0]);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({pc_out, instr_out, valid_out, imem_addr} !== {32'h8, 32'h8001_0829, 1'b1, 32'h8}) begin
      failures++;
      $display("FAIL seq_fetch: pc=%h instr=%h v=%b addr=%h expected 8/80010829/1/8",
               pc_out, instr_out, valid_out, imem_addr);
    end
  endtask

  task automatic test_freeze();
    tick(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 32'h100);
      checks++;
      if ({imem_addr, pc_out, instr_out, valid_out} !== {32'hC, 32'hC, mem[2], 1'b1}) begin
        failures++;
        $display("FAIL freeze_hold%0d: addr=%h pc=%h instr=%h v=%b expected c/c/%h/1",
                 i, imem_addr, pc_out, instr_out, valid_out, mem[2]);
      end
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (stall_count !== 32'd2 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL freeze_counters: stall=%0d fetch=%0d expected 2/3", stall_count, fetch_count);
    end
`endif
    tick(0, 0, 0, 0);
    checks++;
    if ({imem_addr, pc_out, instr_out} !== {32'h10, 32'h10, mem[3]}) begin
      failures++;
      $display("FAIL freeze_resume: addr=%h pc=%h instr=%h expected 10/10/%h",
               imem_addr, pc_out, instr_out, mem[3]);
    end
  endtask

  task automatic test_branch();
    tick(0, 0, 1, 32'h23);
    checks++;
    if ({imem_addr, pc_out, instr_out, valid_out} !== {32'h20, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL branch_bubble: addr=%h pc=%h instr=%h v=%b expected 20/0/0/0",
               imem_addr, pc_out, instr_out, valid_out);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({pc_out, instr_out, valid_out} !== {32'h24, mem[8], 1'b1}) begin
      failures++;
      $display("FAIL branch_target: pc=%h instr=%h v=%b expected 24/%h/1",
               pc_out, instr_out, valid_out, mem[8]);
    end
  endtask

  task automatic test_branch_freeze();
    tick(0, 1, 1, 32'h40);
    checks++;
    if ({imem_addr, pc_out, instr_out, valid_out} !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL branch_freeze: addr=%h pc=%h instr=%h v=%b expected 40/0/0/0",
               imem_addr, pc_out, instr_out, valid_out);
    end
  endtask

  task automatic test_reset_branch_wrap();
    tick(0, 0, 0, 0);
    tick(1, 0, 1, 32'h80);
    checks++;
    if ({imem_addr, valid_out} !== {RESET_PC, 1'b0}) begin
      failures++;
      $display("FAIL reset_branch: addr=%h v=%b expected %h/0", imem_addr, valid_out, RESET_PC);
    end
    tick(0, 0, 1, 32'hFFFF_FFFF);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_setup: addr=%h expected fffffffc", imem_addr);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({imem_addr, pc_out, instr_out, valid_out} !== {32'h0, 32'h0, mem[63], 1'b1}) begin
      failures++;
      $display("FAIL wrap: addr=%h pc=%h instr=%h v=%b expected 0/0/%h/1",
               imem_addr, pc_out, instr_out, valid_out, mem[63]);
    end
  endtask

  task automatic test_random();
    logic r, f, b;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 31) == 0);
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 5) == 0);
      tick(r, f, b, $urandom);
      checks++;
      if ({imem_addr, pc_out, instr_out, valid_out} !== {m_pc, m_pcout, m_instr, m_valid}) begin
        failures++;
        $display("FAIL random[%0d]: addr=%h pc=%h instr=%h v=%b expected %h/%h/%h/%b",
                 i, imem_addr, pc_out, instr_out, valid_out, m_pc, m_pcout, m_instr, m_valid);
      end
`ifdef IF_PERF_CNT_EN
      checks++;
      if ({fetch_count, stall_count} !== {m_fc, m_sc}) begin
        failures++;
        $display("FAIL random_counters[%0d]: fetch=%0d stall=%0d expected %0d/%0d",
                 i, fetch_count, stall_count, m_fc, m_sc);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h8001_0829;
    test_reset();
    test_seq_fetch();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_reset_branch_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
